// File: rtl/alu_cmd_sequencer_pkg.sv
// alu_cmd_sequencer_pkg: shared types and constants for the ALU command sequencer.
//   - ALU opcode constants (OP_ADD .. OP_ROR, OP_MAX = highest legal opcode)
//   - sequencer state encoding
//   - packed response payload
//   - opcode legality helper
package alu_cmd_sequencer_pkg;

  localparam int unsigned DATA_W = 4;

  typedef logic [DATA_W-1:0] data_t;

  // ALU select codes
  localparam data_t OP_ADD = 4'd0;
  localparam data_t OP_SUB = 4'd1;
  localparam data_t OP_AND = 4'd2;
  localparam data_t OP_OR  = 4'd3;
  localparam data_t OP_XOR = 4'd4;
  localparam data_t OP_SHL = 4'd5;
  localparam data_t OP_SHR = 4'd6;
  localparam data_t OP_ROL = 4'd7;
  localparam data_t OP_ROR = 4'd8;
  localparam data_t OP_MAX = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Response payload returned to the command source
  typedef struct packed {
    data_t data;
    logic  carry;
    logic  zero;
    logic  err;
  } rsp_t;

  function automatic logic op_is_legal(input data_t op);
    return (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command-side controller for the 4-bit combinational ALU.
// Accepts load / ALU commands, iterates an ALU operation on the accumulator
// cmd_rep+1 times, then returns the final result on a valid/ready response.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cmd_valid/cmd_ready              command handshake (ready only in IDLE)
//   cmd_op, cmd_operand, cmd_load,   command payload
//   cmd_rep
//   alu_a, alu_b, alu_sel            drive to ALU (accumulator, operand, opcode)
//   alu_out, alu_carry, alu_zero     ALU result, sampled only in EXEC
//   rsp_valid/rsp_ready              response handshake
//   rsp_data, rsp_carry, rsp_zero,   response payload
//   rsp_err
//   acc                              accumulator, always visible
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [3:0]       cmd_operand,
  input  logic             cmd_load,
  input  logic [CNT_W-1:0] cmd_rep,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [3:0]       alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [3:0]       acc
);

  state_e           r_state;
  state_e           w_state_nxt;
  data_t            r_acc;
  data_t            w_acc_nxt;
  data_t            r_op;
  data_t            w_op_nxt;
  data_t            r_operand;
  data_t            w_operand_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  rsp_t             r_rsp;
  rsp_t             w_rsp_nxt;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_op      <= '0;
      r_operand <= '0;
      r_cnt     <= '0;
      r_rsp     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_op      <= w_op_nxt;
      r_operand <= w_operand_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rsp     <= w_rsp_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_op_nxt      = r_op;
    w_operand_nxt = r_operand;
    w_cnt_nxt     = r_cnt;
    w_rsp_nxt     = r_rsp;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          // Load wins over opcode legality: the opcode is ignored for loads
          if (cmd_load) begin
            w_acc_nxt       = cmd_operand;
            w_rsp_nxt.data  = cmd_operand;
            w_rsp_nxt.carry = 1'b0;
            w_rsp_nxt.zero  = (cmd_operand == 4'd0);
            w_rsp_nxt.err   = 1'b0;
            w_state_nxt     = ST_RESP;
          end else if (!op_is_legal(cmd_op)) begin
            w_rsp_nxt.data  = r_acc;
            w_rsp_nxt.carry = 1'b0;
            w_rsp_nxt.zero  = 1'b0;
            w_rsp_nxt.err   = 1'b1;
            w_state_nxt     = ST_RESP;
          end else begin
            w_op_nxt      = cmd_op;
            w_operand_nxt = cmd_operand;
            w_cnt_nxt     = cmd_rep;
            w_state_nxt   = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        // acc feeds alu_a, so each cycle is one full ALU iteration
        w_acc_nxt       = alu_out;
        w_rsp_nxt.carry = alu_carry;
        w_rsp_nxt.zero  = alu_zero;
        if (r_cnt == '0) begin
          w_rsp_nxt.data = alu_out;
          w_rsp_nxt.err  = 1'b0;
          w_state_nxt    = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are pure functions of registered state
  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign alu_a     = r_acc;
  assign alu_b     = r_operand;
  assign alu_sel   = r_op;
  assign acc       = r_acc;
  assign rsp_data  = r_rsp.data;
  assign rsp_carry = r_rsp.carry;
  assign rsp_zero  = r_rsp.zero;
  assign rsp_err   = r_rsp.err;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed + randomized bench for alu_cmd_sequencer.
// A behavioural ALU drives the DUT's ALU inputs; a command-level model
// predicts response payload, latency and accumulator history.
module tb_alu_cmd_sequencer;

  localparam int unsigned CNT_W  = 3;
  localparam int          BUDGET = 40;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [3:0]       cmd_operand;
  logic             cmd_load;
  logic [CNT_W-1:0] cmd_rep;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [3:0]       alu_sel;
  logic [3:0]       alu_out;
  logic             alu_carry;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_data;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_err;
  logic [3:0]       acc;

  int checks   = 0;
  int failures = 0;
  logic [3:0] m_acc;

  alu_cmd_sequencer #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_operand (cmd_operand),
    .cmd_load    (cmd_load),
    .cmd_rep     (cmd_rep),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .alu_carry   (alu_carry),
    .alu_zero    (alu_zero),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_carry   (rsp_carry),
    .rsp_zero    (rsp_zero),
    .rsp_err     (rsp_err),
    .acc         (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 4-bit ALU: returns {carry, zero, result}
  function automatic logic [5:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] sel);
    int        s;
    logic [3:0] res;
    logic       c;
    res = 4'd0;
    c   = 1'b0;
    case (sel)
      4'd0: begin s = int'(a) + int'(b); res = 4'(s % 16); c = (s > 15); end
      4'd1: begin s = int'(a) - int'(b); res = 4'((s + 16) % 16); c = (s < 0); end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: begin res = 4'((int'(a) * 2) % 16); c = (a >= 4'd8); end
      4'd6: begin res = 4'(int'(a) / 2); c = a[0]; end
      4'd7: begin res = 4'(((int'(a) * 2) % 16) + int'(a) / 8); c = (a >= 4'd8); end
      4'd8: begin res = 4'(int'(a) / 2 + (int'(a) % 2) * 8); c = a[0]; end
      default: res = 4'd0;
    endcase
    return {c, (res == 4'd0), res};
  endfunction

  assign {alu_carry, alu_zero, alu_out} = alu_ref(alu_a, alu_b, alu_sel);

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, predict its outcome, follow it to completion
  task automatic run_cmd(input logic ld, input logic [3:0] op, input logic [3:0] opnd,
                         input logic [CNT_W-1:0] rep, input int hold);
    logic [3:0] hist[$];
    logic [3:0] e_data;
    logic [3:0] a;
    logic [5:0] r;
    logic       e_c;
    logic       e_z;
    logic       e_err;
    logic       is_alu;
    int         e_lat;
    int         lat;

    e_c    = 1'b0;
    e_z    = 1'b0;
    is_alu = 1'b0;
    if (ld) begin
      e_data = opnd; e_z = (opnd == 4'd0); e_err = 1'b0; e_lat = 1;
      m_acc  = opnd;
    end else if (op > 4'd8) begin
      e_data = m_acc; e_err = 1'b1; e_lat = 1;
    end else begin
      is_alu = 1'b1;
      a = m_acc;
      for (int i = 0; i <= int'(rep); i++) begin
        r = alu_ref(a, opnd, op);
        a = r[3:0];
        hist.push_back(a);
        e_c = r[5];
        e_z = r[4];
      end
      e_data = a; e_err = 1'b0; e_lat = int'(rep) + 2;
      m_acc  = a;
    end

    check("cmd_ready_idle", 8'(cmd_ready), 8'd1);
    cmd_valid   = 1'b1;
    cmd_load    = ld;
    cmd_op      = op;
    cmd_operand = opnd;
    cmd_rep     = rep;
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < BUDGET) begin
      check("exec_cmd_ready", 8'(cmd_ready), 8'd0);
      if (is_alu && lat >= 2 && (lat - 2) < hist.size())
        check("exec_acc", 8'(acc), 8'(hist[lat-2]));
      tick();
      lat++;
    end
    check("rsp_latency", 8'(lat), 8'(e_lat));
    check("rsp_data", 8'(rsp_data), 8'(e_data));
    check("rsp_carry", 8'(rsp_carry), 8'(e_c));
    check("rsp_zero", 8'(rsp_zero), 8'(e_z));
    check("rsp_err", 8'(rsp_err), 8'(e_err));
    check("acc_after", 8'(acc), 8'(m_acc));
    check("resp_cmd_ready", 8'(cmd_ready), 8'd0);

    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 8'(rsp_valid), 8'd1);
      check("hold_data", 8'({rsp_data, rsp_carry, rsp_zero, rsp_err}),
            8'({e_data, e_c, e_z, e_err}));
      check("hold_cmd_ready", 8'(cmd_ready), 8'd0);
    end

    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_rsp_valid", 8'(rsp_valid), 8'd0);
    check("post_cmd_ready", 8'(cmd_ready), 8'd1);
  endtask

  initial begin
    logic [3:0] rop;
    int         sel;

    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_load    = 1'b0;
    cmd_op      = 4'd0;
    cmd_operand = 4'd0;
    cmd_rep     = '0;
    rsp_ready   = 1'b0;
    m_acc       = 4'd0;

    // Reset values
    tick();
    tick();
    check("rst_cmd_ready", 8'(cmd_ready), 8'd1);
    check("rst_rsp_valid", 8'(rsp_valid), 8'd0);
    check("rst_acc", 8'(acc), 8'd0);
    check("rst_rsp", 8'({rsp_data, rsp_carry, rsp_zero, rsp_err}), 8'd0);
    check("rst_alu_b_sel", 8'({alu_b, alu_sel}), 8'd0);
    rst_n = 1'b1;
    tick();

    // Reset during EXEC aborts the operation
    run_cmd(1'b1, 4'd0, 4'h5, 3'd0, 0);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 4'd7; cmd_operand = 4'd0; cmd_rep = 3'd7;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mid_exec_busy", 8'(cmd_ready), 8'd0);
    rst_n = 1'b0;
    #1;
    check("abort_acc", 8'(acc), 8'd0);
    check("abort_rsp_valid", 8'(rsp_valid), 8'd0);
    check("abort_cmd_ready", 8'(cmd_ready), 8'd1);
    tick();
    check("abort_hold_acc", 8'(acc), 8'd0);
    check("abort_hold_ready", 8'(cmd_ready), 8'd1);
    rst_n = 1'b1;
    m_acc = 4'd0;
    tick();

    // Directed cases
    run_cmd(1'b1, 4'd0, 4'h7, 3'd0, 0);
    run_cmd(1'b0, 4'd0, 4'h3, 3'd0, 0);
    check("add_result", 8'(acc), 8'h0A);
    run_cmd(1'b1, 4'd0, 4'hF, 3'd0, 1);
    run_cmd(1'b0, 4'd0, 4'h1, 3'd0, 0);
    check("add_wrap", 8'(acc), 8'h00);
    run_cmd(1'b1, 4'd0, 4'b1001, 3'd0, 0);
    run_cmd(1'b0, 4'd7, 4'h0, 3'd2, 0);
    check("rol_result", 8'(acc), 8'h0C);
    run_cmd(1'b1, 4'd0, 4'h2, 3'd0, 0);
    run_cmd(1'b0, 4'd1, 4'h3, 3'd0, 5);
    check("sub_result", 8'(acc), 8'h0F);
    run_cmd(1'b1, 4'd0, 4'h6, 3'd0, 0);
    run_cmd(1'b0, 4'hB, 4'h2, 3'd3, 2);
    check("err_acc_kept", 8'(acc), 8'h06);
    run_cmd(1'b1, 4'hF, 4'h0, 3'd5, 0);
    run_cmd(1'b0, 4'd8, 4'h0, 3'd7, 0);

    // Randomized command stream
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 2)
        run_cmd(1'b1, 4'($urandom), 4'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
      else begin
        if (sel == 2) rop = 4'(9 + $urandom_range(0, 6));
        else          rop = 4'($urandom_range(0, 8));
        run_cmd(1'b0, rop, 4'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
